ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
Shares the single data-RAM port between the pipeline memory stage (CPU) and one external requester (program loader / debug probe, "EXT"). The CPU has priority by default. A starvation counter and a bounded lock mode guarantee EXT progress. The CPU is stalled in any cycle it loses the port. The block sits between the memory stage's RAM outputs and the RAM macro; cpu_stall ORs into the pipeline stall.

Parameters:
ADDR_W, 8, RAM word-address width
DATA_W, 32, data width
STARVE_MAX, 4, cycles EXT may wait while CPU holds the port before EXT is forced through (0 = EXT always wins)
LOCK_MAX, 16, max consecutive cycles in LOCKED before the port is returned to the CPU

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  memory stage wants RAM this cycle (load or store)
cpu_write  in  1  store when 1
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU store data
cpu_rdata  out  DATA_W  RAM read data to CPU (combinational)
cpu_stall  out  1  CPU lost the port this cycle; hold the memory stage
ext_valid  in  1  EXT request valid
ext_ready  out  1  EXT request accepted this cycle
ext_write  in  1  EXT write when 1
ext_lock  in  1  keep the port after this transfer
ext_addr  in  ADDR_W  EXT address
ext_wdata  in  DATA_W  EXT write data
ext_rvalid  out  1  EXT read data valid
ext_rdata  out  DATA_W  EXT read data (registered)
ram_address  out  ADDR_W  to RAM
ram_write_enable  out  1  to RAM
ram_write_data  out  DATA_W  to RAM
ram_data  in  DATA_W  RAM read data, asynchronous read

Behaviour:
- States: IDLE, LOCKED. Reset sets state=IDLE, wait_cnt=0, lock_cnt=0, ext_rvalid=0, ext_rdata=0.
- Reset asserted mid-operation clears all state immediately. Any pending ext_rvalid is suppressed.
- grant_ext (combinational):
  - In IDLE: grant_ext = ext_valid && (!cpu_req || wait_cnt==STARVE_MAX).
  - In LOCKED: grant_ext = ext_valid.
- ext_ready = grant_ext. An EXT handshake occurs when ext_valid && ext_ready.
- cpu_stall = cpu_req && (grant_ext || state==LOCKED). In LOCKED the CPU is stalled even if EXT is idle that cycle.
- RAM mux:
  - When grant_ext: drive ext_addr, ext_wdata, and write_enable = ext_write.
  - Otherwise: drive cpu_addr, cpu_wdata, and write_enable = cpu_req && cpu_write && !cpu_stall.
  - A stalled CPU store never writes.
- Idle port: when neither side is granted, ram_write_enable=0 and the address follows cpu_addr.
- cpu_rdata = ram_data always. It is only meaningful when not stalled.
- wait_cnt (IDLE only):
  - Increments, saturating at STARVE_MAX, each cycle ext_valid && !grant_ext.
  - Clears on an EXT handshake or when ext_valid=0.
- Transition IDLE→LOCKED: EXT handshake with ext_lock=1. lock_cnt is set to 1.
- In LOCKED, lock_cnt increments every cycle. Return to IDLE on the first of:
  - EXT handshake with ext_lock=0 (that transfer completes, IDLE from next cycle);
  - lock_cnt==LOCK_MAX at a clock edge.
- On return to IDLE, wait_cnt=0. A further ext_lock=1 handshake while already LOCKED does not reset lock_cnt.
- EXT read: on a handshake with ext_write=0, ext_rdata <= ram_data at that edge. ext_rvalid=1 for exactly the next cycle. Back-to-back reads give back-to-back rvalid pulses.
- EXT write: no response pulse.
- Simultaneous cpu_req and ext_valid with wait_cnt<STARVE_MAX in IDLE: CPU wins, EXT waits.
- CPU has no starvation guarantee beyond LOCK_MAX. Outside LOCKED, at most one forced EXT transfer occurs per STARVE_MAX+1 cycles.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined, two extra outputs exist:
  - stat_ext_grants[15:0]: EXT handshakes.
  - stat_cpu_stalls[15:0]: cycles with cpu_stall=1.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- CPU-only traffic: store 0xDEADBEEF to addr 0x10, then load 0x10 → cpu_stall=0 throughout; cpu_rdata=0xDEADBEEF the cycle after the store.
- EXT-only: write 0x12345678 to 0x20, then read 0x20 → ext_ready=1 each cycle; ext_rvalid pulses one cycle after the read with ext_rdata=0x12345678.
- Contention (STARVE_MAX=4): cpu_req held high and ext_valid raised at cycle 0 → ext_ready=0 for cycles 0–3; at cycle 4 ext_ready=1 and cpu_stall=1, and a CPU store issued that cycle is not written; wait_cnt returns to 0.
- Lock burst (LOCK_MAX=16): 3 EXT writes with ext_lock=1,1,0 while cpu_req=1 → cpu_stall=1 across the burst; IDLE, and CPU granted, the cycle after the third write.
- Lock timeout: ext_lock held 1 with continuous ext_valid → the port returns to IDLE after 16 LOCKED cycles; the CPU is granted the next contended cycle.
- Reset asserted the cycle after an EXT read handshake → ext_rvalid stays 0 and the state is IDLE immediately; normal operation resumes after deassertion.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single data-RAM port between the CPU memory stage and an external requester.
// Optional statistics counters are built when RAM_ARB_STATS_EN is defined.
module ram_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic              ext_write,
  input  logic              ext_lock,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_write_enable,
  output logic [DATA_W-1:0] ram_write_data,
  input  logic [DATA_W-1:0] ram_data
`ifdef RAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_ext_grants,
  output logic [15:0]       stat_cpu_stalls
`endif
);

  localparam int WAIT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int LOCK_W = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(STARVE_MAX);
  localparam logic [LOCK_W-1:0] LOCK_LIM = LOCK_W'(LOCK_MAX);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              ext_rvalid_q, ext_rvalid_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              grant_ext_s;
  logic              handshake_s;

  // Port grant: EXT wins when the CPU is idle, when EXT has starved long enough, or while locked
  always_comb begin
    grant_ext_s = 1'b0;
    case (state_q)
      ST_IDLE:   grant_ext_s = ext_valid && (!cpu_req || (wait_cnt_q == WAIT_SAT));
      ST_LOCKED: grant_ext_s = ext_valid;
      default:   grant_ext_s = 1'b0;
    endcase
  end

  assign handshake_s = ext_valid && grant_ext_s;
  assign ext_ready   = grant_ext_s;
  assign cpu_stall   = cpu_req && (grant_ext_s || (state_q == ST_LOCKED));
  assign cpu_rdata   = ram_data;
  assign ext_rvalid  = ext_rvalid_q;
  assign ext_rdata   = ext_rdata_q;

  // RAM port mux; an idle port tracks the CPU address with writes disabled
  always_comb begin
    if (grant_ext_s) begin
      ram_address      = ext_addr;
      ram_write_data   = ext_wdata;
      ram_write_enable = ext_write;
    end else begin
      ram_address      = cpu_addr;
      ram_write_data   = cpu_wdata;
      ram_write_enable = cpu_req && cpu_write && !cpu_stall;
    end
  end

  // Starvation and lock bookkeeping
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (handshake_s || !ext_valid) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_SAT) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
        if (handshake_s && ext_lock) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = LOCK_W'(1);
        end else begin
          lock_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        wait_cnt_d = '0;
        // A lock=1 handshake keeps counting so a locked burst can never exceed LOCK_MAX cycles
        if ((handshake_s && !ext_lock) || (lock_cnt_q == LOCK_LIM)) begin
          state_d    = ST_IDLE;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = '0;
        lock_cnt_d = '0;
      end
    endcase
  end

  // EXT read response captures the asynchronous RAM data at the handshake edge
  always_comb begin
    ext_rvalid_d = handshake_s && !ext_write;
    if (ext_rvalid_d) begin
      ext_rdata_d = ram_data;
    end else begin
      ext_rdata_d = ext_rdata_q;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      ext_rvalid_q <= 1'b0;
      ext_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      ext_rvalid_q <= ext_rvalid_d;
      ext_rdata_q  <= ext_rdata_d;
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [15:0] stat_ext_grants_q, stat_ext_grants_d;
  logic [15:0] stat_cpu_stalls_q, stat_cpu_stalls_d;

  // Saturating event counters
  always_comb begin
    if (handshake_s && (stat_ext_grants_q != 16'hFFFF)) begin
      stat_ext_grants_d = stat_ext_grants_q + 16'd1;
    end else begin
      stat_ext_grants_d = stat_ext_grants_q;
    end
    if (cpu_stall && (stat_cpu_stalls_q != 16'hFFFF)) begin
      stat_cpu_stalls_d = stat_cpu_stalls_q + 16'd1;
    end else begin
      stat_cpu_stalls_d = stat_cpu_stalls_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ext_grants_q <= 16'd0;
      stat_cpu_stalls_q <= 16'd0;
    end else begin
      stat_ext_grants_q <= stat_ext_grants_d;
      stat_cpu_stalls_q <= stat_cpu_stalls_d;
    end
  end

  assign stat_ext_grants = stat_ext_grants_q;
  assign stat_cpu_stalls = stat_cpu_stalls_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
